// File: rtl/controle_escrita_pkg.sv
// Shared encodings for the register-bank write-back sequencer: command codes,
// address/data selector codes and FSM states.
package controle_escrita_pkg;

  localparam logic [2:0] CmdRt   = 3'b000;
  localparam logic [2:0] CmdRd   = 3'b001;
  localparam logic [2:0] CmdSp   = 3'b010;
  localparam logic [2:0] CmdLink = 3'b011;
  localparam logic [2:0] CmdPop  = 3'b100;
  localparam logic [2:0] CmdCall = 3'b101;

  localparam logic [1:0] SelEndRt = 2'b00;
  localparam logic [1:0] SelEndRd = 2'b01;
  localparam logic [1:0] SelEnd29 = 2'b10;
  localparam logic [1:0] SelEnd31 = 2'b11;

  localparam logic [1:0] SEL_DADO_ULA = 2'b00;
  localparam logic [1:0] SEL_DADO_MEM = 2'b01;
  localparam logic [1:0] SEL_DADO_PC  = 2'b10;
  localparam logic [1:0] SEL_DADO_SP  = 2'b11;

  typedef enum logic [1:0] {
    StOcioso   = 2'b00,
    StEscrita1 = 2'b01,
    StEscrita2 = 2'b10,
    StErro     = 2'b11
  } estado_e;

endpackage

// File: rtl/decod_cmd_escrita.sv
// Combinational decoder: (command, write step) -> selectors plus two-write and
// illegal flags.
module decod_cmd_escrita
  import controle_escrita_pkg::*;
(
  input  logic [2:0] cmd_i,
  input  logic       passo_i,
  output logic [1:0] sel_end_o,
  output logic [1:0] sel_dado_o,
  output logic       dupla_o,
  output logic       ilegal_o
);

  always_comb begin
    sel_end_o  = SelEndRt;
    sel_dado_o = SEL_DADO_ULA;
    dupla_o    = 1'b0;
    ilegal_o   = 1'b0;
    case (cmd_i)
      CmdRt:   begin sel_end_o = SelEndRt; sel_dado_o = SEL_DADO_ULA; end
      CmdRd:   begin sel_end_o = SelEndRd; sel_dado_o = SEL_DADO_ULA; end
      CmdSp:   begin sel_end_o = SelEnd29; sel_dado_o = SEL_DADO_SP;  end
      CmdLink: begin sel_end_o = SelEnd31; sel_dado_o = SEL_DADO_PC;  end
      CmdPop:  begin sel_end_o = SelEndRt; sel_dado_o = SEL_DADO_MEM; dupla_o = 1'b1; end
      CmdCall: begin sel_end_o = SelEnd31; sel_dado_o = SEL_DADO_PC;  dupla_o = 1'b1; end
      default: ilegal_o = 1'b1;
    endcase
    // Every second write is the stack-pointer update.
    if (passo_i) begin
      sel_end_o  = SelEnd29;
      sel_dado_o = SEL_DADO_SP;
    end
  end

endmodule

// File: rtl/controle_escrita_reg.sv
// Write-back port sequencer: one handshaked command becomes one or two write
// cycles. Optional macro WB_GUARDA_ZERO_EN suppresses writes to register $0.
module controle_escrita_reg
  import controle_escrita_pkg::*;
#(
  parameter int unsigned LARGURA_CONT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmdValido,
  output logic                    cmdPronto,
  input  logic [2:0]              cmd,
  input  logic [4:0]              valorInstrucao16to20,
  input  logic [4:0]              valorInstrucao11to15,
  output logic [1:0]              seletorMuxEscritaEndereco,
  output logic [1:0]              seletorMuxEscritaDado,
  output logic                    regWrite,
  output logic                    fimEscrita,
  output logic                    erroCmd,
  output logic [LARGURA_CONT-1:0] contadorEscritas
);

  estado_e                 estado_q, estado_d;
  logic [2:0]              cmd_q, cmd_d;
  logic [4:0]              rt_q, rt_d;
  logic [4:0]              rd_q, rd_d;
  logic [LARGURA_CONT-1:0] cont_q, cont_d;

  logic [2:0] cmd_dec;
  logic [1:0] sel_end, sel_dado;
  logic       dupla, ilegal, escrevendo, aceita, grava;

  // While idle the decoder looks at the incoming command only to pick the
  // next state; outputs are forced to zero in that state.
  assign cmd_dec = (estado_q == StOcioso) ? cmd : cmd_q;

  decod_cmd_escrita u_decod (
    .cmd_i     (cmd_dec),
    .passo_i   (estado_q == StEscrita2),
    .sel_end_o (sel_end),
    .sel_dado_o(sel_dado),
    .dupla_o   (dupla),
    .ilegal_o  (ilegal)
  );

  assign escrevendo = (estado_q == StEscrita1) || (estado_q == StEscrita2);
  assign cmdPronto  = (estado_q == StOcioso) && !reset;
  assign aceita     = cmdValido && cmdPronto;

`ifdef WB_GUARDA_ZERO_EN
  logic end_zero;
  assign end_zero = ((sel_end == SelEndRt) && (rt_q == 5'd0)) ||
                    ((sel_end == SelEndRd) && (rd_q == 5'd0));
  assign grava    = escrevendo && !end_zero;
`else
  assign grava    = escrevendo;
`endif

  always_comb begin
    estado_d = estado_q;
    cmd_d    = cmd_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    cont_d   = cont_q + {{(LARGURA_CONT-1){1'b0}}, grava};
    case (estado_q)
      StOcioso: begin
        if (aceita) begin
          cmd_d    = cmd;
          rt_d     = valorInstrucao16to20;
          rd_d     = valorInstrucao11to15;
          estado_d = ilegal ? StErro : StEscrita1;
        end
      end
      StEscrita1: estado_d = dupla ? StEscrita2 : StOcioso;
      StEscrita2: estado_d = StOcioso;
      default:    estado_d = StOcioso;
    endcase
  end

  always_comb begin
    regWrite                  = grava;
    fimEscrita                = ((estado_q == StEscrita1) && !dupla) ||
                                (estado_q == StEscrita2);
    erroCmd                   = (estado_q == StErro);
    seletorMuxEscritaEndereco = escrevendo ? sel_end  : 2'b00;
    seletorMuxEscritaDado     = escrevendo ? sel_dado : 2'b00;
    contadorEscritas          = cont_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= StOcioso;
      cmd_q    <= 3'b000;
      rt_q     <= 5'd0;
      rd_q     <= 5'd0;
      cont_q   <= '0;
    end else begin
      estado_q <= estado_d;
      cmd_q    <= cmd_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
      cont_q   <= cont_d;
    end
  end

endmodule

// File: tb/tb_controle_escrita_reg.sv
// Bench for controle_escrita_reg: a queue of expected write cycles per command,
// checked every cycle, plus literal expectations from hand-worked scenarios.
module tb_controle_escrita_reg;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmdValido = 1'b0;
  logic [2:0]   cmd = 3'b000;
  logic [4:0]   rt_in = 5'd0;
  logic [4:0]   rd_in = 5'd0;
  logic         cmdPronto, regWrite, fimEscrita, erroCmd;
  logic [1:0]   selEnd, selDado;
  logic [W-1:0] contador;

  int checks = 0;
  int errors = 0;

  controle_escrita_reg #(.LARGURA_CONT(W)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .cmdValido                (cmdValido),
    .cmdPronto                (cmdPronto),
    .cmd                      (cmd),
    .valorInstrucao16to20     (rt_in),
    .valorInstrucao11to15     (rd_in),
    .seletorMuxEscritaEndereco(selEnd),
    .seletorMuxEscritaDado    (selDado),
    .regWrite                 (regWrite),
    .fimEscrita               (fimEscrita),
    .erroCmd                  (erroCmd),
    .contadorEscritas         (contador)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       err;
    logic [1:0] a;
    logic [1:0] d;
    logic       w;
    logic       last;
  } ciclo_t;

  ciclo_t       fila[$];
  logic [W-1:0] m_cont = '0;

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nome, act, exp, $time);
    end
  endtask

  function automatic logic habilita(input logic [1:0] a, input logic [4:0] rt, input logic [4:0] rd);
`ifdef WB_GUARDA_ZERO_EN
    if (a == 2'b00) return rt != 5'd0;
    if (a == 2'b01) return rd != 5'd0;
`endif
    return 1'b1;
  endfunction

  function automatic ciclo_t escrita(input logic [1:0] a, input logic [1:0] d, input logic last,
                                     input logic [4:0] rt, input logic [4:0] rd);
    ciclo_t c;
    c.err = 1'b0; c.a = a; c.d = d; c.last = last; c.w = habilita(a, rt, rd);
    return c;
  endfunction

  task automatic aceita_modelo(input logic [2:0] c, input logic [4:0] rt, input logic [4:0] rd);
    ciclo_t e;
    case (c)
      3'd0: fila.push_back(escrita(2'b00, 2'b00, 1'b1, rt, rd));
      3'd1: fila.push_back(escrita(2'b01, 2'b00, 1'b1, rt, rd));
      3'd2: fila.push_back(escrita(2'b10, 2'b11, 1'b1, rt, rd));
      3'd3: fila.push_back(escrita(2'b11, 2'b10, 1'b1, rt, rd));
      3'd4: begin
        fila.push_back(escrita(2'b00, 2'b01, 1'b0, rt, rd));
        fila.push_back(escrita(2'b10, 2'b11, 1'b1, rt, rd));
      end
      3'd5: begin
        fila.push_back(escrita(2'b11, 2'b10, 1'b0, rt, rd));
        fila.push_back(escrita(2'b10, 2'b11, 1'b1, rt, rd));
      end
      default: begin
        e.err = 1'b1; e.a = 2'b00; e.d = 2'b00; e.w = 1'b0; e.last = 1'b0;
        fila.push_back(e);
      end
    endcase
  endtask

  task automatic modelo_borda();
    if (reset) begin
      fila.delete();
      m_cont = '0;
    end else if (fila.size() > 0) begin
      if (fila[0].w) m_cont = m_cont + 1'b1;
      void'(fila.pop_front());
    end else if (cmdValido) begin
      aceita_modelo(cmd, rt_in, rd_in);
    end
  endtask

  task automatic compara();
    ciclo_t e;
    e.err = 1'b0; e.a = 2'b00; e.d = 2'b00; e.w = 1'b0; e.last = 1'b0;
    if (fila.size() > 0) e = fila[0];
    chk("cmdPronto", {31'd0, cmdPronto}, {31'd0, (fila.size() == 0) && !reset});
    chk("regWrite", {31'd0, regWrite}, {31'd0, e.w});
    chk("selEnd", {30'd0, selEnd}, {30'd0, e.a});
    chk("selDado", {30'd0, selDado}, {30'd0, e.d});
    chk("fimEscrita", {31'd0, fimEscrita}, {31'd0, e.last});
    chk("erroCmd", {31'd0, erroCmd}, {31'd0, e.err});
    chk("contador", {{(32-W){1'b0}}, contador}, {{(32-W){1'b0}}, m_cont});
  endtask

  task automatic ciclo();
    @(posedge clk);
    modelo_borda();
    @(negedge clk);
    compara();
  endtask

  logic [2:0] seq_cmd [12];

  initial begin
    seq_cmd = '{3'd0, 3'd2, 3'd3, 3'd5, 3'd6, 3'd1, 3'd4, 3'd7, 3'd0, 3'd5, 3'd3, 3'd2};

    // Reset held three cycles.
    repeat (3) ciclo();
    chk("rst_pronto", {31'd0, cmdPronto}, 32'd0);
    chk("rst_regwrite", {31'd0, regWrite}, 32'd0);
    reset = 1'b0;
    #1;
    chk("pronto_after_rst", {31'd0, cmdPronto}, 32'd1);
    chk("cont_after_rst", {28'd0, contador}, 32'd0);
    ciclo();

    // RD: rd=5, rt=9.
    cmd = 3'd1; rd_in = 5'd5; rt_in = 5'd9; cmdValido = 1'b1;
    ciclo();
    cmdValido = 1'b0;
    chk("rd_regwrite", {31'd0, regWrite}, 32'd1);
    chk("rd_selend", {30'd0, selEnd}, 32'd1);
    chk("rd_seldado", {30'd0, selDado}, 32'd0);
    chk("rd_fim", {31'd0, fimEscrita}, 32'd1);
    ciclo();
    chk("rd_pronto", {31'd0, cmdPronto}, 32'd1);
    chk("rd_cont", {28'd0, contador}, 32'd1);

    // POP with rt changed after accept.
    cmd = 3'd4; rt_in = 5'd8; cmdValido = 1'b1;
    ciclo();
    cmdValido = 1'b0; rt_in = 5'd3;
    chk("pop1_selend", {30'd0, selEnd}, 32'd0);
    chk("pop1_seldado", {30'd0, selDado}, 32'd1);
    chk("pop1_fim", {31'd0, fimEscrita}, 32'd0);
    ciclo();
    chk("pop2_selend", {30'd0, selEnd}, 32'd2);
    chk("pop2_seldado", {30'd0, selDado}, 32'd3);
    chk("pop2_fim", {31'd0, fimEscrita}, 32'd1);
    ciclo();
    chk("pop_cont", {28'd0, contador}, 32'd3);

    // Illegal command.
    cmd = 3'd7; cmdValido = 1'b1;
    ciclo();
    cmdValido = 1'b0;
    chk("ilegal_erro", {31'd0, erroCmd}, 32'd1);
    chk("ilegal_regwrite", {31'd0, regWrite}, 32'd0);
    ciclo();
    chk("ilegal_pronto", {31'd0, cmdPronto}, 32'd1);
    chk("ilegal_cont", {28'd0, contador}, 32'd3);

    // Back-to-back stream, command changing every cycle while valid stays high.
    cmdValido = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cmd = seq_cmd[i % 12];
      rt_in = 5'(i + 1);
      rd_in = 5'(i + 2);
      ciclo();
    end
    cmdValido = 1'b0;
    repeat (3) ciclo();

    // RT to register 0.
    cmd = 3'd0; rt_in = 5'd0; cmdValido = 1'b1;
    ciclo();
    cmdValido = 1'b0;
`ifdef WB_GUARDA_ZERO_EN
    chk("zero_regwrite", {31'd0, regWrite}, 32'd0);
`else
    chk("zero_regwrite", {31'd0, regWrite}, 32'd1);
`endif
    chk("zero_fim", {31'd0, fimEscrita}, 32'd1);
    ciclo();

    // Reset during the first CALL write.
    cmd = 3'd5; cmdValido = 1'b1;
    ciclo();
    cmdValido = 1'b0;
    chk("call1_regwrite", {31'd0, regWrite}, 32'd1);
    reset = 1'b1;
    ciclo();
    chk("abort_regwrite", {31'd0, regWrite}, 32'd0);
    chk("abort_selend", {30'd0, selEnd}, 32'd0);
    chk("abort_cont", {28'd0, contador}, 32'd0);
    reset = 1'b0;
    ciclo();
    chk("abort_idle_regwrite", {31'd0, regWrite}, 32'd0);

    // 17 single writes wrap the 4-bit counter to 1.
    cmd = 3'd0; rt_in = 5'd1; cmdValido = 1'b1;
    repeat (34) ciclo();
    cmdValido = 1'b0;
    chk("wrap_cont", {28'd0, contador}, 32'd1);
    repeat (2) ciclo();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
